// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - mode codes, FSM states and mode helper for the sequential shifter
package shift_pkg;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ROR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Reserved codes pass the operand through untouched.
    function automatic logic is_reserved(input logic [2:0] m);
        return !(m inside {MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR});
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift/rotate of acc by k (0..STEP) positions
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int KW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [KW-1:0]    k,
    input  logic [2:0]       op,
    input  logic             sign,
    output logic [WIDTH-1:0] res
);

    // A chain of single-bit moves keeps every intermediate at WIDTH bits.
    always_comb begin
        res = acc;
        for (int j = 0; j < STEP; j++) begin
            if (KW'(j) < k) begin
                case (op)
                    MODE_SLL: res = {res[WIDTH-2:0], 1'b0};
                    MODE_SRL: res = {1'b0, res[WIDTH-1:1]};
                    MODE_SRA: res = {sign, res[WIDTH-1:1]};
                    MODE_ROL: res = {res[WIDTH-2:0], res[WIDTH-1]};
                    MODE_ROR: res = {res[0], res[WIDTH-1:1]};
                    default:  res = res;
                endcase
            end
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle shifter with start/busy/done handshake, STEP bits per cycle
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] shamt,
    input  logic [2:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int AW = $clog2(WIDTH);
    localparam int KW = $clog2(STEP + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic [2:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic             done_q, done_d;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] step_res;

    // Only amount mod WIDTH matters; upper shamt bits are intentionally dropped.
    logic unused_shamt;
    assign unused_shamt = ^shamt[WIDTH-1:AW];

    always_comb begin
        if (int'(rem_q) >= STEP) k = KW'(STEP);
        else                     k = KW'(rem_q);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc   (acc_q),
        .k     (k),
        .op    (op_q),
        .sign  (sign_q),
        .res   (step_res)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        sign_d  = sign_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    acc_d   = in;
                    rem_d   = is_reserved(mode) ? '0 : shamt[AW-1:0];
                    op_d    = mode;
                    sign_d  = in[WIDTH-1];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (rem_q != '0) begin
                    acc_d = step_res;
                    rem_d = rem_q - AW'(k);
                end else begin
                    out_d   = acc_q;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            out_q   <= '0;
            rem_q   <= '0;
            op_q    <= MODE_SLL;
            sign_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - randomized self-checking bench for seq_shift_unit
module tb_seq_shift_unit;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_in = '0;
    logic [W-1:0] shamt = '0;
    logic [2:0]   mode  = 3'b000;
    logic         busy;
    logic         done;
    logic [W-1:0] out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] s;
        logic [2:0]  m;
        logic [31:0] e;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    seq_shift_unit #(.WIDTH(W), .STEP(S)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (op_in),
        .shamt (shamt),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit known_mode(input logic [2:0] m);
        return (m == 3'b000) || (m == 3'b001) || (m == 3'b011) || (m == 3'b100) || (m == 3'b101);
    endfunction

    function automatic logic [31:0] ref_out(input logic [31:0] a, input logic [31:0] s, input logic [2:0] m);
        int amt;
        logic [63:0] dbl;
        amt = int'(s % 32);
        dbl = {a, a};
        case (m)
            3'b000:  return a << amt;
            3'b001:  return a >> amt;
            3'b011:  return $unsigned($signed(a) >>> amt);
            3'b100:  return dbl[63-amt -: 32];
            3'b101:  return dbl[31+amt -: 32];
            default: return a;
        endcase
    endfunction

    function automatic int ref_lat(input logic [31:0] s, input logic [2:0] m);
        int amt;
        amt = int'(s % 32);
        if (!known_mode(m)) return 1;
        return 1 + (amt + S - 1) / S;
    endfunction

    // Called at a negedge; leaves the bench at the negedge after the accepting edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] s, input logic [2:0] m, input string tag);
        start = 1'b1;
        op_in = a;
        shamt = s;
        mode  = m;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op_in = $urandom;
        shamt = $urandom;
        mode  = 3'($urandom);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Junk on start/inputs while busy must be ignored.
    task automatic wait_done(input logic [31:0] exp, input int lat, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!done) begin
                start = 1'($urandom_range(0, 1));
                op_in = $urandom;
                shamt = $urandom;
                mode  = 3'($urandom);
            end
        end while (!done && n < 200);
        start = 1'b0;
        check_eq({tag, "_lat"}, 32'(n), 32'(lat));
        check_eq({tag, "_out"}, out, exp);
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic gap(input logic [31:0] exp, input string tag);
        @(negedge clk);
        check_eq({tag, "_done_width"}, 32'(done), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        check_eq({tag, "_held"}, out, exp);
    endtask

    initial begin
        logic [31:0] a, s, e;
        logic [2:0]  m;

        vecs[0]  = '{32'd6541,       32'd3,  3'b000, 32'd52328};
        vecs[1]  = '{32'd6541,       32'd3,  3'b001, 32'd817};
        vecs[2]  = '{32'd6541,       32'd3,  3'b011, 32'd817};
        vecs[3]  = '{32'hFFFF_FFC0,  32'd3,  3'b001, 32'h1FFF_FFF8};
        vecs[4]  = '{32'hFFFF_FFC0,  32'd3,  3'b011, 32'hFFFF_FFF8};
        vecs[5]  = '{32'hFFFF_FFC0,  32'd3,  3'b000, 32'hFFFF_FE00};
        vecs[6]  = '{32'h1234_5678,  32'd8,  3'b101, 32'h7812_3456};
        vecs[7]  = '{32'h8000_0001,  32'd4,  3'b100, 32'h0000_0018};
        vecs[8]  = '{32'hDEAD_BEEF,  32'd0,  3'b000, 32'hDEAD_BEEF};
        vecs[9]  = '{32'hDEAD_BEEF,  32'd32, 3'b001, 32'hDEAD_BEEF};
        vecs[10] = '{32'h8000_0000,  32'd31, 3'b011, 32'hFFFF_FFFF};
        vecs[11] = '{32'hCAFE_F00D,  32'd5,  3'b110, 32'hCAFE_F00D};

        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_out", out, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].s, vecs[i].m, $sformatf("dir%0d", i));
            wait_done(vecs[i].e, ref_lat(vecs[i].s, vecs[i].m), $sformatf("dir%0d", i));
            gap(vecs[i].e, $sformatf("dir%0d", i));
        end

        launch(32'h0000_00F0, 32'd4, 3'b001, "b2b_a");
        wait_done(32'h0000_000F, 2, "b2b_a");
        launch(32'h0000_0003, 32'd9, 3'b000, "b2b_b");
        wait_done(32'h0000_0600, 4, "b2b_b");
        gap(32'h0000_0600, "b2b_b");

        launch(32'h8000_0000, 32'd31, 3'b011, "arst");
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_out", out, 32'd0);
        @(negedge clk);
        check_eq("arst_hold_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("arst_idle", 32'(busy), 32'd0);
        launch(32'h1234_5678, 32'd12, 3'b100, "post_rst");
        wait_done(32'h4567_8123, 4, "post_rst");
        gap(32'h4567_8123, "post_rst");

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            s = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            m = 3'($urandom_range(0, 7));
            e = ref_out(a, s, m);
            launch(a, s, m, $sformatf("rnd%0d", i));
            wait_done(e, ref_lat(s, m), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) gap(e, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
